// File: rtl/scan_keypad_pkg.sv
// Shared types, sizes and helpers for the 4x4 keypad scanner.
package scan_keypad_pkg;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned ROW_W = 2;
    localparam int unsigned COL_W = 2;
    localparam int unsigned KEY_W = ROW_W + COL_W;

    typedef enum logic [1:0] {
        StScan     = 2'd0,
        StDebounce = 2'd1,
        StPressed  = 2'd2
    } state_e;

    // Index of the lowest active-low column; multi-key presses resolve to the lowest column.
    function automatic logic [COL_W-1:0] lowest_low_col(input logic [COLS-1:0] cols);
        logic [COL_W-1:0] idx;
        idx = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!cols[i]) begin
                idx = COL_W'(i);
            end
        end
        return idx;
    endfunction

    // Active-low one-cold row drive for a row index.
    function automatic logic [ROWS-1:0] row_drive(input logic [ROW_W-1:0] row);
        logic [ROWS-1:0] one_hot;
        one_hot      = '0;
        one_hot[row] = 1'b1;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/scan_keypad_if.sv
// Keypad pin and key-event bundle; master is the scanner, slave is the board/consumer side.
interface scan_keypad_if;
    import scan_keypad_pkg::*;

    logic [COLS-1:0]  col_in;
    logic [ROWS-1:0]  row_sel;
    logic             key_valid;
    logic [KEY_W-1:0] key_code;
    logic             key_held;

    modport master (
        input  col_in,
        output row_sel,
        output key_valid,
        output key_code,
        output key_held
    );

    modport slave (
        output col_in,
        input  row_sel,
        input  key_valid,
        input  key_code,
        input  key_held
    );

endinterface

// File: rtl/scan_keypad_sync_2ff.sv
// Two-flop synchronizer for asynchronous keypad column inputs.
module scan_keypad_sync_2ff #(
    parameter int unsigned      Width    = 4,
    parameter logic [Width-1:0] ResetVal = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q, meta_d;
    logic [Width-1:0] sync_q, sync_d;

    // Shift the raw input through two stages.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchronous reset to the idle (all columns released) level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/scan_keypad.sv
// 4x4 matrix keypad scanner: row scan, press/release debounce, one-cycle key strobe.
module scan_keypad
    import scan_keypad_pkg::*;
#(
    parameter int unsigned ROW_DWELL       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic          clk_1K,
    input  logic          reset,
    scan_keypad_if.master kp_if
);

    localparam int unsigned DwellW = $clog2(ROW_DWELL);
    localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DwellW-1:0] DwellLast = DwellW'(ROW_DWELL - 1);
    localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [DwellW-1:0]  dwell_q, dwell_d;
    logic [DebW-1:0]    deb_q, deb_d;
    logic               key_valid_q, key_valid_d;
    logic [KEY_W-1:0]   key_code_q, key_code_d;
    logic               key_held_q, key_held_d;

    logic [COLS-1:0]    col_s;
    logic               col_low;

    scan_keypad_sync_2ff #(
        .Width    (COLS),
        .ResetVal ({COLS{1'b1}})
    ) u_col_sync (
        .clk_i (clk_1K),
        .rst_i (reset),
        .d_i   (kp_if.col_in),
        .q_o   (col_s)
    );

    // The column latched at detection; other columns are ignored until release.
    assign col_low = ~col_s[col_q];

    // Next-state for scan, debounce and release tracking.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;

        unique case (state_q)
            StScan: begin
                if (dwell_q == DwellLast) begin
                    if (col_s == {COLS{1'b1}}) begin
                        row_d   = row_q + 1'b1;
                        dwell_d = '0;
                    end else begin
                        col_d   = lowest_low_col(col_s);
                        deb_d   = '0;
                        state_d = StDebounce;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            StDebounce: begin
                if (col_low) begin
                    if (deb_q == DebLast) begin
                        key_valid_d = 1'b1;
                        key_code_d  = {row_q, col_q};
                        key_held_d  = 1'b1;
                        deb_d       = '0;
                        state_d     = StPressed;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    // Bounce or glitch: abandon and move on to the next row.
                    row_d   = row_q + 1'b1;
                    dwell_d = '0;
                    state_d = StScan;
                end
            end
            StPressed: begin
                if (!col_low) begin
                    if (deb_q == DebLast) begin
                        key_held_d = 1'b0;
                        row_d      = row_q + 1'b1;
                        dwell_d    = '0;
                        deb_d      = '0;
                        state_d    = StScan;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    // Release must be seen on consecutive cycles; any low restarts it.
                    deb_d = '0;
                end
            end
            default: begin
                state_d    = StScan;
                row_d      = '0;
                col_d      = '0;
                dwell_d    = '0;
                deb_d      = '0;
                key_code_d = '0;
                key_held_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset has priority over everything.
    always_ff @(posedge clk_1K) begin
        if (reset) begin
            state_q     <= StScan;
            row_q       <= '0;
            col_q       <= '0;
            dwell_q     <= '0;
            deb_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp_if.row_sel   = row_drive(row_q);
    assign kp_if.key_valid = key_valid_q;
    assign kp_if.key_code  = key_code_q;
    assign kp_if.key_held  = key_held_q;

endmodule

// File: tb/tb_scan_keypad.sv
// Randomized bench for scan_keypad against a behavioural keypad/scanner reference.
module tb_scan_keypad;
    import scan_keypad_pkg::*;

    localparam int unsigned DWELL = 4;
    localparam int unsigned DEB   = 4;

    localparam int MODE_SCAN    = 0;
    localparam int MODE_CONFIRM = 1;
    localparam int MODE_HOLD    = 2;

    logic clk_1K = 1'b0;
    logic reset  = 1'b1;

    always #5 clk_1K = ~clk_1K;

    scan_keypad_if kp_if ();

    scan_keypad #(
        .ROW_DWELL       (DWELL),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk_1K (clk_1K),
        .reset  (reset),
        .kp_if  (kp_if)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit prev_valid = 1'b0;

    // Closed switches, bit index = row*4 + col.
    logic [15:0] keys = '0;

    // Reference state.
    int         m_mode, m_row, m_tick, m_run, m_col;
    logic [3:0] m_pipe[$];
    bit         m_valid, m_held;
    logic [3:0] m_code;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Column levels a physical keypad presents for the currently driven row.
    function automatic logic [3:0] pad_cols(input logic [15:0] k, input logic [3:0] rows);
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (rows[r] === 1'b0) begin
                for (int j = 0; j < 4; j++) begin
                    if (k[r*4+j]) c[j] = 1'b0;
                end
            end
        end
        return c;
    endfunction

    // Reference behaviour for one clock edge given reset and the pin levels at that edge.
    task automatic model_step(input bit rst, input logic [3:0] col);
        logic [3:0] seen;
        bit         line_low;
        if (rst) begin
            m_pipe.delete();
            m_pipe.push_back(4'hF);
            m_pipe.push_back(4'hF);
            m_mode  = MODE_SCAN;
            m_row   = 0;
            m_tick  = 0;
            m_run   = 0;
            m_col   = 0;
            m_valid = 1'b0;
            m_held  = 1'b0;
            m_code  = 4'h0;
            return;
        end
        seen = m_pipe[1];
        m_pipe.push_front(col);
        void'(m_pipe.pop_back());
        m_valid  = 1'b0;
        line_low = (seen[m_col] == 1'b0);
        case (m_mode)
            MODE_SCAN: begin
                if (m_tick + 1 < DWELL) begin
                    m_tick++;
                end else if (seen == 4'hF) begin
                    m_row  = (m_row + 1) % 4;
                    m_tick = 0;
                end else begin
                    for (int c = 3; c >= 0; c--) if (!seen[c]) m_col = c;
                    m_run  = 0;
                    m_mode = MODE_CONFIRM;
                end
            end
            MODE_CONFIRM: begin
                if (line_low) begin
                    m_run++;
                    if (m_run == DEB) begin
                        m_valid = 1'b1;
                        m_code  = 4'(m_row * 4 + m_col);
                        m_held  = 1'b1;
                        m_run   = 0;
                        m_mode  = MODE_HOLD;
                    end
                end else begin
                    m_row  = (m_row + 1) % 4;
                    m_tick = 0;
                    m_mode = MODE_SCAN;
                end
            end
            default: begin
                if (line_low) begin
                    m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == DEB) begin
                        m_held = 1'b0;
                        m_row  = (m_row + 1) % 4;
                        m_tick = 0;
                        m_run  = 0;
                        m_mode = MODE_SCAN;
                    end
                end
            end
        endcase
    endtask

    // One clock: drive at the falling edge, compare 1 time unit after the rising edge.
    task automatic step(input bit rst);
        logic [3:0] col;
        @(negedge clk_1K);
        reset = rst;
        col = pad_cols(keys, kp_if.row_sel);
        kp_if.col_in = col;
        model_step(rst, col);
        @(posedge clk_1K);
        #1;
        check_eq("row_sel", kp_if.row_sel, 4'hF ^ (4'h1 << m_row));
        check_eq("key_valid", kp_if.key_valid, m_valid);
        check_eq("key_code", kp_if.key_code, m_code);
        check_eq("key_held", kp_if.key_held, m_held);
        if (prev_valid) check_eq("valid_gap", kp_if.key_valid, 1'b0);
        if (kp_if.key_valid === 1'b1) pulses++;
        prev_valid = (kp_if.key_valid === 1'b1);
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic wait_held(input string tag);
        int n = 0;
        while (kp_if.key_held !== 1'b1 && n < 80) begin
            step(1'b0);
            n++;
        end
        check_eq(tag, kp_if.key_held, 1'b1);
    endtask

    task automatic wait_mode(input string tag, input int mode);
        int n = 0;
        while (m_mode != mode && n < 80) begin
            step(1'b0);
            n++;
        end
        check_eq(tag, n < 80, 1'b1);
    endtask

    initial begin
        kp_if.col_in = 4'hF;

        // 1: reset, idle scan every DWELL cycles with wrap.
        step(1'b1);
        step(1'b1);
        check_eq("t1_rst_row", kp_if.row_sel, 4'hE);
        check_eq("t1_rst_held", kp_if.key_held, 1'b0);
        check_eq("t1_rst_code", kp_if.key_code, 4'h0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0);
            check_eq("t1_row", kp_if.row_sel, 4'hF ^ (4'h1 << ((i / 4) % 4)));
        end
        check_eq("t1_pulses", pulses, 0);

        // 2: stable press of (2,1), then release.
        pulses = 0;
        keys = '0;
        keys[9] = 1'b1;
        wait_held("t2_held_wait");
        run(10);
        check_eq("t2_pulses", pulses, 1);
        check_eq("t2_code", kp_if.key_code, 4'h9);
        keys = '0;
        run(3);
        check_eq("t2_held_after_release", kp_if.key_held, 1'b1);
        run(10);
        check_eq("t2_released", kp_if.key_held, 1'b0);

        // 3: short glitch on (2,1) aborts and scanning continues at row 3.
        pulses = 0;
        keys[9] = 1'b1;
        wait_mode("t3_confirm_wait", MODE_CONFIRM);
        keys = '0;
        wait_mode("t3_scan_wait", MODE_SCAN);
        check_eq("t3_next_row", kp_if.row_sel, 4'b0111);
        run(20);
        check_eq("t3_pulses", pulses, 0);

        // 4: two keys in row 1, lowest column wins; partial release keeps it held.
        pulses = 0;
        keys[4] = 1'b1;
        keys[7] = 1'b1;
        wait_held("t4_held_wait");
        run(5);
        check_eq("t4_code", kp_if.key_code, 4'h4);
        keys[7] = 1'b0;
        run(20);
        check_eq("t4_still_held", kp_if.key_held, 1'b1);
        check_eq("t4_pulses", pulses, 1);
        keys = '0;
        run(15);
        check_eq("t4_released", kp_if.key_held, 1'b0);

        // 5: release bounce shorter than the debounce window.
        keys[9] = 1'b1;
        wait_held("t5_held_wait");
        pulses = 0;
        keys = '0;
        run(2);
        keys[9] = 1'b1;
        run(20);
        check_eq("t5_held", kp_if.key_held, 1'b1);
        check_eq("t5_pulses", pulses, 0);
        keys = '0;
        run(15);
        check_eq("t5_released", kp_if.key_held, 1'b0);

        // 6: reset while pressed.
        keys[0] = 1'b1;
        wait_held("t6_held_wait");
        step(1'b1);
        check_eq("t6_row", kp_if.row_sel, 4'hE);
        check_eq("t6_held", kp_if.key_held, 1'b0);
        check_eq("t6_code", kp_if.key_code, 4'h0);
        check_eq("t6_valid", kp_if.key_valid, 1'b0);
        keys = '0;
        run(10);

        // Randomized presses with bounce and occasional resets.
        for (int it = 0; it < 40; it++) begin
            logic [15:0] chosen;
            int          n_keys;
            int          hold;
            chosen = '0;
            n_keys = $urandom_range(0, 2);
            for (int k = 0; k < n_keys; k++) chosen[$urandom_range(0, 15)] = 1'b1;
            hold = $urandom_range(0, 45);
            for (int c = 0; c < hold; c++) begin
                keys = ($urandom_range(0, 7) == 0) ? 16'h0 : chosen;
                step($urandom_range(0, 99) == 0);
            end
            keys = '0;
            hold = $urandom_range(0, 30);
            for (int c = 0; c < hold; c++) step($urandom_range(0, 99) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
